branch_resolve_tracker: RTL

BRANCH_RESOLVE_TRACKER -- requirements
Module: branch_resolve_tracker

---
 rtl/branch_resolve_tracker.sv | 95 +++++++++
 1 files changed

// File: rtl/branch_resolve_tracker.sv
// Tracks outstanding branch predictions in a circular FIFO, matches them against
// in-order resolutions, and produces predictor-training, mispredict and statistics outputs.
module branch_resolve_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     pred_valid,
  input  logic [1:0]               prediction,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic                     unexp_res,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_L = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] dir_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   pending_nxt;
  logic             push;
  logic             pop;
  logic             miss;
  logic             head_dir;
  logic             unused_pred_lsb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Only the direction bit is stored; counter strength is irrelevant after prediction.
  assign unused_pred_lsb = prediction[0];

  assign pred_ready = (pending < DEPTH_L);
  assign head_dir   = dir_q[rd_ptr];
  assign push       = pred_valid & pred_ready;
  assign pop        = res_valid & (pending != '0);
  assign miss       = pop & (res_taken != head_dir);

  always_comb begin
    pending_nxt = pending;
    case ({push, pop})
      2'b10:   pending_nxt = pending + (PTR_W+1)'(1);
      2'b01:   pending_nxt = pending - (PTR_W+1)'(1);
      default: pending_nxt = pending;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) dir_q[wr_ptr] <= prediction[1];
  end

  // Resolution stage: everything below is registered one cycle after the resolving edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      upd_valid  <= 1'b0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      unexp_res  <= 1'b0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      upd_valid  <= pop;
      mispredict <= miss;
      unexp_res  <= res_valid & ~pop;
      if (pop) begin
        upd_taken  <= res_taken;
        branch_cnt <= sat_inc(branch_cnt);
      end
      if (miss) miss_cnt <= sat_inc(miss_cnt);
      // A mispredict squashes every younger entry, including a push on this same edge.
      if (miss) begin
        pending <= '0;
        rd_ptr  <= wr_ptr;
      end else begin
        pending <= pending_nxt;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule
